program_sequencer: RTL and testbench

Controller that owns the MC14500B Wrapper's program-load port and its core reset/enable.
- Accepts a program stream over a valid/ready handshake and writes it word-by-word into program memory.
- Holds the core in reset during the load, then releases it and runs it for a bounded number of cycles.
- Captures output_pins as the run result.
- Sits between the host/testbench interface and the Wrapper.

---
 rtl/program_sequencer_pkg.sv | 38 +++
 rtl/seq_run_counter.sv | 43 ++++
 rtl/program_sequencer.sv | 150 +++++++++++++++
 tb/tb_program_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the MC14500B program sequencer:
// FSM state encoding, default instruction width and opcodes for building programs.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    CORE_RST = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } seq_state_t;

  localparam int INSTR_WIDTH_DEFAULT = 12;

  // MC14500B opcodes (upper nibble of a program word)
  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  function automatic logic [11:0] make_instr(input logic [3:0] op, input logic [7:0] addr);
    return {op, addr};
  endfunction

endpackage

// File: rtl/seq_run_counter.sv
// Run-cycle counter: clear, enable, saturation at all-ones, and a latched
// limit whose hit flag marks the final counted cycle (limit 0 never hits).
module seq_run_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         load_limit_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         hit_o
);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] limit_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      count_q <= count_d;
      if (load_limit_i) begin
        limit_q <= limit_i;
      end
    end
  end

  assign count_o = count_q;
  assign hit_o   = (limit_q != '0) && (count_q == limit_q - W'(1));

endmodule

// File: rtl/program_sequencer.sv
// Loads a program into the MC14500B wrapper, holds the core in reset, runs it for a
// bounded number of cycles and captures its outputs. Optional SEQ_SINGLE_STEP_EN adds step control.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  parameter int OUTPUT_SIZE = 5,
  parameter int RST_CYCLES  = 2,
  parameter int LIMIT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  // load stream: a word transfers on a cycle where load_valid && load_ready are both high
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  input  logic [LIMIT_WIDTH-1:0] run_limit,
  input  logic                   halt_req,
  input  logic [OUTPUT_SIZE-1:0] core_outputs,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                   step_mode,
  input  logic                   step_req,
`endif
  output logic                   prog_write,
  output logic [ADDR_WIDTH-1:0]  prog_addr,
  output logic [INSTR_WIDTH-1:0] prog_cmd,
  output logic                   core_reset,
  output logic                   core_en,
  output logic [ADDR_WIDTH:0]    words_loaded,
  output logic [LIMIT_WIDTH-1:0] cycle_count,
  output logic [OUTPUT_SIZE-1:0] result,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output seq_state_t             dbg_state
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  seq_state_t             state_q, state_d;
  logic                   load_ready_q, prog_write_q, core_reset_q, core_en_q, core_en_d;
  logic                   busy_q, done_q, error_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, prog_addr_q;
  logic [INSTR_WIDTH-1:0] prog_cmd_q;
  logic [ADDR_WIDTH:0]    words_loaded_q;
  logic [OUTPUT_SIZE-1:0] result_q;
  logic [RCW-1:0]         rst_cnt_q;
  logic                   xfer, run_exit, rst_done, cnt_hit, cnt_en, cnt_clear;

  always_comb begin
    state_d  = state_q;
    xfer     = load_ready_q && load_valid && !abort;
    run_exit = (state_q == RUN) && !abort && (halt_req || (core_en_q && cnt_hit));
    rst_done = (rst_cnt_q == RCW'(RST_CYCLES - 1));
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: if (start) state_d = LOAD;
        LOAD: begin
          // the word at the top address is still written before ERR is entered
          if (xfer && load_last)                state_d = CORE_RST;
          else if (xfer && (wr_addr_q == '1))   state_d = ERR;
        end
        CORE_RST: if (rst_done) state_d = RUN;
        RUN:      if (run_exit) state_d = DONE;
        default:  state_d = IDLE;
      endcase
    end
`ifdef SEQ_SINGLE_STEP_EN
    // a step request during an active enable pulse is dropped
    core_en_d = (state_d == RUN) && (!step_mode || (step_req && !core_en_q));
`else
    core_en_d = (state_d == RUN);
`endif
  end

  assign cnt_en    = (state_q == RUN) && core_en_q && !run_exit && !abort;
  assign cnt_clear = (state_q == CORE_RST) && !abort;

  seq_run_counter #(.W(LIMIT_WIDTH)) u_run_counter (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (cnt_clear),
    .load_limit_i (cnt_clear),
    .en_i         (cnt_en),
    .limit_i      (run_limit),
    .count_o      (cycle_count),
    .hit_o        (cnt_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      load_ready_q   <= 1'b0;
      prog_write_q   <= 1'b0;
      core_reset_q   <= 1'b1;
      core_en_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      wr_addr_q      <= '0;
      prog_addr_q    <= '0;
      prog_cmd_q     <= '0;
      words_loaded_q <= '0;
      result_q       <= '0;
      rst_cnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= (state_d == LOAD);
      core_reset_q <= !((state_d == RUN) || (state_d == DONE));
      core_en_q    <= core_en_d;
      busy_q       <= (state_d inside {LOAD, CORE_RST, RUN});
      done_q       <= (state_d == DONE);
      error_q      <= (state_d == ERR);
      prog_write_q <= xfer;
      if (xfer) begin
        prog_addr_q    <= wr_addr_q;
        prog_cmd_q     <= load_data;
        wr_addr_q      <= wr_addr_q + ADDR_WIDTH'(1);
        words_loaded_q <= words_loaded_q + (ADDR_WIDTH + 1)'(1);
      end else if ((state_d == LOAD) && (state_q != LOAD)) begin
        wr_addr_q      <= '0;
        words_loaded_q <= '0;
      end
      rst_cnt_q <= ((state_q == CORE_RST) && (state_d == CORE_RST)) ? rst_cnt_q + RCW'(1) : '0;
      if (run_exit) begin
        result_q <= core_outputs;
      end
    end
  end

  assign load_ready   = load_ready_q;
  assign prog_write   = prog_write_q;
  assign prog_addr    = prog_addr_q;
  assign prog_cmd     = prog_cmd_q;
  assign core_reset   = core_reset_q;
  assign core_en      = core_en_q;
  assign words_loaded = words_loaded_q;
  assign result       = result_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a cycle model of the sequencing rules plus an
// expected-write queue, compared every cycle, with hand-computed checks per scenario.
module tb_program_sequencer;

  localparam int AW    = 8;
  localparam int IW    = 12;
  localparam int OS    = 5;
  localparam int RC    = 2;
  localparam int LW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk, reset, start, abort, load_valid, load_last, halt_req;
  logic [IW-1:0] load_data;
  logic [LW-1:0] run_limit;
  logic [OS-1:0] core_outputs;
  logic          load_ready, prog_write, core_reset, core_en, busy, done, error;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_cmd;
  logic [AW:0]   words_loaded;
  logic [LW-1:0] cycle_count;
  logic [OS-1:0] result;
  program_sequencer_pkg::seq_state_t dbg_state;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step_mode, step_req;
`endif

  int n_checks = 0;
  int n_errors = 0;

  program_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .run_limit    (run_limit),
    .halt_req     (halt_req),
    .core_outputs (core_outputs),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode    (step_mode),
    .step_req     (step_req),
`endif
    .prog_write   (prog_write),
    .prog_addr    (prog_addr),
    .prog_cmd     (prog_cmd),
    .core_reset   (core_reset),
    .core_en      (core_en),
    .words_loaded (words_loaded),
    .cycle_count  (cycle_count),
    .result       (result),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, state=%s", dbg_state.name());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_CRST = 2, M_RUN = 3, M_DONE = 4, M_ERR = 5;
  int     m_mode, m_waddr, m_wl, m_cc, m_lim, m_rst_left, m_res;
  bit     m_en, en_now, stop;
  logic [AW+IW-1:0] exp_q[$];
  logic [AW+IW-1:0] wr_log[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_waddr = 0; m_wl = 0; m_cc = 0; m_lim = 0;
      m_rst_left = 0; m_res = 0; m_en = 0;
      exp_q.delete();
    end else begin
      en_now = m_en;
      if (abort) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE, M_DONE, M_ERR: if (start) begin m_mode = M_LOAD; m_waddr = 0; m_wl = 0; end
          M_LOAD: if (load_valid) begin
            exp_q.push_back({AW'(m_waddr), load_data});
            if (load_last) begin m_mode = M_CRST; m_rst_left = RC; end
            else if (m_waddr == DEPTH - 1) m_mode = M_ERR;
            m_waddr++;
            m_wl++;
          end
          M_CRST: begin
            m_cc = 0;
            m_lim = int'(run_limit);
            m_rst_left--;
            if (m_rst_left == 0) m_mode = M_RUN;
          end
          M_RUN: begin
            stop = halt_req || (en_now && m_lim != 0 && m_cc == m_lim - 1);
            if (stop) begin m_mode = M_DONE; m_res = int'(core_outputs); end
            else if (en_now && m_cc < (1 << LW) - 1) m_cc++;
          end
          default: ;
        endcase
      end
`ifdef SEQ_SINGLE_STEP_EN
      m_en = (m_mode == M_RUN) && (!step_mode || (step_req && !en_now));
`else
      m_en = (m_mode == M_RUN);
`endif
    end
  end

  // ---------------- scoreboard / monitors ----------------
  int en_cnt = 0, crst_cnt = 0, done_rises = 0, last_run_out = 0;
  bit prev_done = 0;
  logic [AW+IW-1:0] exp_w;

  always @(negedge clk) begin
    chk("load_ready",   load_ready,   m_mode == M_LOAD);
    chk("core_reset",   core_reset,   !(m_mode == M_RUN || m_mode == M_DONE));
    chk("core_en",      core_en,      m_en);
    chk("busy",         busy,         m_mode == M_LOAD || m_mode == M_CRST || m_mode == M_RUN);
    chk("done",         done,         m_mode == M_DONE);
    chk("error",        error,        m_mode == M_ERR);
    chk("words_loaded", words_loaded, m_wl);
    chk("cycle_count",  cycle_count,  m_cc);
    chk("result",       result,       m_res);
    chk("prog_write",   prog_write,   exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      if (prog_write) chk("prog_word", {prog_addr, prog_cmd}, exp_w);
    end
    if (prog_write) wr_log.push_back({prog_addr, prog_cmd});
    if (core_en) begin en_cnt++; last_run_out = int'(core_outputs); end
    if (core_reset && busy && !load_ready) crst_cnt++;
    if (done && !prev_done) done_rises++;
    prev_done = done;
  end

  // free-running stand-in for the wrapper's output pins
  always @(posedge clk) begin
    #1 core_outputs = core_outputs + OS'(3);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input int base, input int step, input bit with_last);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = IW'(base + i * step);
      load_last  = with_last && (i == n - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // which: 0 = running, 1 = done, 2 = error
  task automatic wait_cond(input int which, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (which == 0 && !core_reset && busy) return;
      if (which == 1 && done) return;
      if (which == 2 && error) return;
      tick();
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout after %0d cycles, state=%s", tag, limit, dbg_state.name());
  endtask

  // ---------------- directed scenarios ----------------
  logic [AW+IW-1:0] t1_exp [4] = '{20'h00101, 20'h01202, 20'h02303, 20'h03404};
  int r0;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; load_valid = 1'b0; load_data = '0;
    load_last = 1'b0; run_limit = '0; halt_req = 1'b0; core_outputs = '0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0; step_req = 1'b0;
`endif
    #2 reset = 1'b0;
    tick();
    chk("rst core_reset", core_reset, 1);
    chk("rst busy", busy, 0);
    chk("rst words_loaded", words_loaded, 0);
    chk("rst prog_write", prog_write, 0);
    tick();
    reset = 1'b1;
    tick();

    // 1/2: four-word load then a 10-cycle run
    run_limit = 16'd10;
    wr_log.delete(); en_cnt = 0; crst_cnt = 0;
    pulse_start();
    send_words(4, 'h101, 'h101, 1'b1);
    wait_cond(1, 60, "t1 done");
    chk("t1 write count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1 write word", wr_log[i], t1_exp[i]);
    chk("t1 words_loaded", words_loaded, 4);
    chk("t1 core_rst cycles", crst_cnt, 2);
    chk("t2 run cycles", en_cnt, 10);
    chk("t2 cycle_count", cycle_count, 9);
    chk("t2 done", done, 1);
    chk("t2 result", result, last_run_out);

    // 3: overflow with load_last never set
    wr_log.delete();
    pulse_start();
    send_words(256, 0, 3, 1'b0);
    wait_cond(2, 10, "t3 error");
    tick(); tick();
    chk("t3 error", error, 1);
    chk("t3 busy", busy, 0);
    chk("t3 words_loaded", words_loaded, 256);
    chk("t3 write count", wr_log.size(), 256);
    chk("t3 last write", wr_log[255], 20'hFF2FD);
    run_limit = 16'd3;
    wr_log.delete();
    pulse_start();
    chk("t3 error cleared", error, 0);
    send_words(1, 'h555, 0, 1'b1);
    wait_cond(1, 40, "t3 rerun done");
    chk("t3 restart addr", wr_log[0], 20'h00555);
    chk("t3 restart words", words_loaded, 1);

    // 4: gapped stream then abort with a word on offer
    wr_log.delete();
    pulse_start();
    chk("t4 ready a", load_ready, 1);
    load_valid = 1'b1; load_data = program_sequencer_pkg::make_instr(program_sequencer_pkg::OP_LD, 8'hAA);
    tick();
    load_valid = 1'b0;
    tick();
    chk("t4 ready b", load_ready, 1);
    load_valid = 1'b1; load_data = program_sequencer_pkg::make_instr(program_sequencer_pkg::OP_STO, 8'hBB);
    tick();
    load_data = 12'hCCC; abort = 1'b1;
    tick();
    abort = 1'b0; load_valid = 1'b0;
    chk("t4 busy", busy, 0);
    chk("t4 core_reset", core_reset, 1);
    chk("t4 load_ready", load_ready, 0);
    chk("t4 words kept", words_loaded, 2);
    tick(); tick();
    chk("t4 write count", wr_log.size(), 2);
    chk("t4 write 0", wr_log[0], 20'h001AA);
    chk("t4 write 1", wr_log[1], 20'h018BB);

    // 5: unlimited run halted at cycle 37, then halt coinciding with limit
    run_limit = 16'd0;
    pulse_start();
    send_words(2, 'h300, 1, 1'b1);
    wait_cond(0, 20, "t5 run");
    repeat (37) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("t5 done", done, 1);
    chk("t5 cycle_count", cycle_count, 37);
    run_limit = 16'd5;
    pulse_start();
    send_words(1, 'h7, 0, 1'b1);
    wait_cond(0, 20, "t5b run");
    r0 = done_rises;
    repeat (4) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    repeat (3) tick();
    chk("t5b done", done, 1);
    chk("t5b cycle_count", cycle_count, 4);
    chk("t5b done entries", done_rises - r0, 1);

    // 6: asynchronous reset in the middle of a run
    run_limit = 16'd0;
    pulse_start();
    send_words(1, 'h9, 0, 1'b1);
    wait_cond(0, 20, "t6 run");
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("t6 core_en", core_en, 0);
    chk("t6 core_reset", core_reset, 1);
    chk("t6 prog_write", prog_write, 0);
    chk("t6 busy", busy, 0);
    tick();
    reset = 1'b1;
    tick();

`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b1;
    pulse_start();
    send_words(1, 'hA, 0, 1'b1);
    wait_cond(0, 20, "t6 step run");
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      tick(); tick();
    end
    chk("t6 step pulses", en_cnt, 3);
    chk("t6 step cycle_count", cycle_count, 3);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    step_mode = 1'b0;
    tick();
    chk("t6 step done", done, 1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
